// File: rtl/toy_vec_dispatch.sv
// Vector instruction dispatcher: an in-order instruction queue whose head is
// issued to one of three units (ALU, MTX, LSU) once it is hazard-free.
// MTX issues are spaced by a busy counter; LSU destinations stay pending in a
// short delay line so that dependent readers (RAW) and later loads to the same
// register (WAW) wait until the writeback window has passed.

package toy_vpack;
    localparam int V_OPC_WIDTH     = 8;
    localparam int V_REG_IDX_WIDTH = 6;

    localparam logic [1:0] UNIT_ALU = 2'd0;
    localparam logic [1:0] UNIT_MTX = 2'd1;
    localparam logic [1:0] UNIT_LSU = 2'd2;
    localparam logic [1:0] UNIT_ILL = 2'd3;
endpackage

module toy_vec_dispatch
    import toy_vpack::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int MTX_BUSY_CYC = 8,
    parameter int LSU_WB_CYC   = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         inst_vld,
    output logic                         inst_rdy,
    input  logic [1:0]                   inst_unit,
    input  logic [V_OPC_WIDTH-1:0]       inst_opcode,
    input  logic [V_REG_IDX_WIDTH-1:0]   inst_vs1,
    input  logic [V_REG_IDX_WIDTH-1:0]   inst_vs2,
    input  logic [V_REG_IDX_WIDTH-1:0]   inst_rd,
    output logic                         vmtx_op_en,
    output logic [V_OPC_WIDTH-1:0]       vmtx_opcode,
    output logic [V_REG_IDX_WIDTH-1:0]   vmtx_vs1,
    output logic [V_REG_IDX_WIDTH-1:0]   vmtx_vs2,
    output logic                         valu_op_en,
    output logic [V_OPC_WIDTH-1:0]       valu_opcode,
    output logic [V_REG_IDX_WIDTH-1:0]   valu_vs1,
    output logic [V_REG_IDX_WIDTH-1:0]   valu_vs2,
    output logic [4:0]                   valu_rd,
    output logic                         vlsu_op_en,
    output logic [V_OPC_WIDTH-1:0]       vlsu_opcode,
    output logic [V_REG_IDX_WIDTH-1:0]   vlsu_vs1,
    output logic [V_REG_IDX_WIDTH-1:0]   vlsu_vs2,
    output logic [V_REG_IDX_WIDTH-1:0]   vlsu_rd,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_cnt,
    output logic                         err_unit
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int MTX_W = $clog2(MTX_BUSY_CYC) + 1;

    // The cycle in which a load is issued is the first cycle of its pending
    // window (the dependent instruction is still behind it in the queue), so
    // only LSU_WB_CYC-1 registered stages are needed to cover the window.
    localparam int   DL_DEPTH = (LSU_WB_CYC > 1) ? (LSU_WB_CYC - 1) : 1;
    localparam logic DL_EN    = (LSU_WB_CYC > 1) ? 1'b1 : 1'b0;

    localparam logic [CNT_W-1:0]           DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]           CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]           CNT_ONE   = CNT_W'(1'b1);
    localparam logic [PTR_W-1:0]           PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0]           PTR_ONE   = PTR_W'(1'b1);
    localparam logic [MTX_W-1:0]           MTX_ZERO  = {MTX_W{1'b0}};
    localparam logic [MTX_W-1:0]           MTX_ONE   = MTX_W'(1'b1);
    localparam logic [MTX_W-1:0]           MTX_LOAD  = MTX_W'(MTX_BUSY_CYC - 1);
    localparam logic [V_OPC_WIDTH-1:0]     OPC_ZERO  = {V_OPC_WIDTH{1'b0}};
    localparam logic [V_REG_IDX_WIDTH-1:0] IDX_ZERO  = {V_REG_IDX_WIDTH{1'b0}};

    // Register-index match against one delay-line entry.
    function automatic logic reg_hit(input logic                       vld,
                                     input logic [V_REG_IDX_WIDTH-1:0] a,
                                     input logic [V_REG_IDX_WIDTH-1:0] b);
        reg_hit = vld & (a == b);
    endfunction

    // Queue storage
    logic [1:0]                 q_unit_r [FIFO_DEPTH];
    logic [V_OPC_WIDTH-1:0]     q_opc_r  [FIFO_DEPTH];
    logic [V_REG_IDX_WIDTH-1:0] q_vs1_r  [FIFO_DEPTH];
    logic [V_REG_IDX_WIDTH-1:0] q_vs2_r  [FIFO_DEPTH];
    logic [V_REG_IDX_WIDTH-1:0] q_rd_r   [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             rdy_r;

    logic [MTX_W-1:0] mtx_cnt_r;

    logic                       dl_vld_r [DL_DEPTH];
    logic [V_REG_IDX_WIDTH-1:0] dl_rd_r  [DL_DEPTH];

    logic [1:0]                 head_unit_s;
    logic [V_OPC_WIDTH-1:0]     head_opc_s;
    logic [V_REG_IDX_WIDTH-1:0] head_vs1_s;
    logic [V_REG_IDX_WIDTH-1:0] head_vs2_s;
    logic [V_REG_IDX_WIDTH-1:0] head_rd_s;
    logic                       head_vld_s;
    logic                       raw_s;
    logic                       waw_s;
    logic                       iss_alu_s;
    logic                       iss_mtx_s;
    logic                       iss_lsu_s;
    logic                       drop_s;
    logic                       push_s;
    logic                       pop_s;

    assign inst_rdy = rdy_r;
    assign fifo_cnt = cnt_r;

    // Head fields and RAW/WAW hazard detection against pending load destinations.
    always_comb begin
        head_unit_s = q_unit_r[rd_ptr_r];
        head_opc_s  = q_opc_r[rd_ptr_r];
        head_vs1_s  = q_vs1_r[rd_ptr_r];
        head_vs2_s  = q_vs2_r[rd_ptr_r];
        head_rd_s   = q_rd_r[rd_ptr_r];
        raw_s       = 1'b0;
        waw_s       = 1'b0;
        for (int i = 0; i < DL_DEPTH; i++) begin
            raw_s = raw_s | reg_hit(dl_vld_r[i], dl_rd_r[i], head_vs1_s)
                          | reg_hit(dl_vld_r[i], dl_rd_r[i], head_vs2_s);
            waw_s = waw_s | reg_hit(dl_vld_r[i], dl_rd_r[i], head_rd_s);
        end
    end

    // Issue/drop decision for the queue head; flush suppresses every action.
    always_comb begin
        head_vld_s = (cnt_r != CNT_ZERO) && !flush;
        iss_alu_s  = 1'b0;
        iss_mtx_s  = 1'b0;
        iss_lsu_s  = 1'b0;
        drop_s     = 1'b0;
        if (head_vld_s) begin
            case (head_unit_s)
                UNIT_ALU: iss_alu_s = !raw_s;
                UNIT_MTX: iss_mtx_s = !raw_s && (mtx_cnt_r == MTX_ZERO);
                UNIT_LSU: iss_lsu_s = !raw_s && !waw_s;
                default:  drop_s    = 1'b1;
            endcase
        end else begin
            drop_s = 1'b0;
        end
        pop_s  = iss_alu_s | iss_mtx_s | iss_lsu_s | drop_s;
        push_s = inst_vld && rdy_r && !flush;
    end

    // Next occupancy: push minus pop, cleared by flush.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (flush) begin
            cnt_nxt_s = CNT_ZERO;
        end else begin
            case ({push_s, pop_s})
                2'b10:   cnt_nxt_s = cnt_r + CNT_ONE;
                2'b01:   cnt_nxt_s = cnt_r - CNT_ONE;
                default: cnt_nxt_s = cnt_r;
            endcase
        end
    end

    // Queue storage write on accepted instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                q_unit_r[i] <= 2'd0;
                q_opc_r[i]  <= OPC_ZERO;
                q_vs1_r[i]  <= IDX_ZERO;
                q_vs2_r[i]  <= IDX_ZERO;
                q_rd_r[i]   <= IDX_ZERO;
            end
        end else if (push_s) begin
            q_unit_r[wr_ptr_r] <= inst_unit;
            q_opc_r[wr_ptr_r]  <= inst_opcode;
            q_vs1_r[wr_ptr_r]  <= inst_vs1;
            q_vs2_r[wr_ptr_r]  <= inst_vs2;
            q_rd_r[wr_ptr_r]   <= inst_rd;
        end
    end

    // Queue pointers, occupancy and ready; ready depends only on registered occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            cnt_r    <= CNT_ZERO;
            rdy_r    <= 1'b0;
        end else if (flush) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            cnt_r    <= CNT_ZERO;
            rdy_r    <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            cnt_r <= cnt_nxt_s;
            rdy_r <= (cnt_nxt_s < DEPTH_CNT);
        end
    end

    // MTX busy counter: reload on MTX issue, otherwise count down to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtx_cnt_r <= MTX_ZERO;
        end else if (iss_mtx_s) begin
            mtx_cnt_r <= MTX_LOAD;
        end else if (mtx_cnt_r != MTX_ZERO) begin
            mtx_cnt_r <= mtx_cnt_r - MTX_ONE;
        end
    end

    // Load-destination delay line: new load enters stage 0, older entries shift out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DL_DEPTH; i++) begin
                dl_vld_r[i] <= 1'b0;
                dl_rd_r[i]  <= IDX_ZERO;
            end
        end else begin
            dl_vld_r[0] <= iss_lsu_s & DL_EN;
            dl_rd_r[0]  <= iss_lsu_s ? head_rd_s : IDX_ZERO;
            for (int i = 1; i < DL_DEPTH; i++) begin
                dl_vld_r[i] <= dl_vld_r[i-1];
                dl_rd_r[i]  <= dl_rd_r[i-1];
            end
        end
    end

    // Registered issue outputs: fields are zero whenever the unit's op_en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vmtx_op_en  <= 1'b0;
            vmtx_opcode <= OPC_ZERO;
            vmtx_vs1    <= IDX_ZERO;
            vmtx_vs2    <= IDX_ZERO;
            valu_op_en  <= 1'b0;
            valu_opcode <= OPC_ZERO;
            valu_vs1    <= IDX_ZERO;
            valu_vs2    <= IDX_ZERO;
            valu_rd     <= 5'd0;
            vlsu_op_en  <= 1'b0;
            vlsu_opcode <= OPC_ZERO;
            vlsu_vs1    <= IDX_ZERO;
            vlsu_vs2    <= IDX_ZERO;
            vlsu_rd     <= IDX_ZERO;
            err_unit    <= 1'b0;
        end else begin
            vmtx_op_en  <= iss_mtx_s;
            vmtx_opcode <= iss_mtx_s ? head_opc_s : OPC_ZERO;
            vmtx_vs1    <= iss_mtx_s ? head_vs1_s : IDX_ZERO;
            vmtx_vs2    <= iss_mtx_s ? head_vs2_s : IDX_ZERO;
            valu_op_en  <= iss_alu_s;
            valu_opcode <= iss_alu_s ? head_opc_s : OPC_ZERO;
            valu_vs1    <= iss_alu_s ? head_vs1_s : IDX_ZERO;
            valu_vs2    <= iss_alu_s ? head_vs2_s : IDX_ZERO;
            valu_rd     <= iss_alu_s ? head_rd_s[4:0] : 5'd0;
            vlsu_op_en  <= iss_lsu_s;
            vlsu_opcode <= iss_lsu_s ? head_opc_s : OPC_ZERO;
            vlsu_vs1    <= iss_lsu_s ? head_vs1_s : IDX_ZERO;
            vlsu_vs2    <= iss_lsu_s ? head_vs2_s : IDX_ZERO;
            vlsu_rd     <= iss_lsu_s ? head_rd_s : IDX_ZERO;
            err_unit    <= drop_s;
        end
    end

endmodule

// File: tb/tb_toy_vec_dispatch.sv
// Scoreboard bench for toy_vec_dispatch: stimulus pushes the expected issue
// events into a queue; a negedge monitor pops and compares each event the DUT
// presents, including its cycle (absolute or as a gap from the previous event).
module tb_toy_vec_dispatch;
    import toy_vpack::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       inst_vld = 1'b0;
    logic       inst_rdy;
    logic [1:0] inst_unit = 2'd0;
    logic [7:0] inst_opcode = 8'd0;
    logic [5:0] inst_vs1 = 6'd0, inst_vs2 = 6'd0, inst_rd = 6'd0;
    logic       vmtx_op_en, valu_op_en, vlsu_op_en, err_unit;
    logic [7:0] vmtx_opcode, valu_opcode, vlsu_opcode;
    logic [5:0] vmtx_vs1, vmtx_vs2, valu_vs1, valu_vs2, vlsu_vs1, vlsu_vs2, vlsu_rd;
    logic [4:0] valu_rd;
    logic [2:0] fifo_cnt;

    toy_vec_dispatch #(.FIFO_DEPTH(4), .MTX_BUSY_CYC(8), .LSU_WB_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .inst_vld(inst_vld), .inst_rdy(inst_rdy), .inst_unit(inst_unit),
        .inst_opcode(inst_opcode), .inst_vs1(inst_vs1), .inst_vs2(inst_vs2), .inst_rd(inst_rd),
        .vmtx_op_en(vmtx_op_en), .vmtx_opcode(vmtx_opcode), .vmtx_vs1(vmtx_vs1), .vmtx_vs2(vmtx_vs2),
        .valu_op_en(valu_op_en), .valu_opcode(valu_opcode), .valu_vs1(valu_vs1), .valu_vs2(valu_vs2),
        .valu_rd(valu_rd),
        .vlsu_op_en(vlsu_op_en), .vlsu_opcode(vlsu_opcode), .vlsu_vs1(vlsu_vs1), .vlsu_vs2(vlsu_vs2),
        .vlsu_rd(vlsu_rd),
        .fifo_cnt(fifo_cnt), .err_unit(err_unit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] kind;     // 0 ALU, 1 MTX, 2 LSU, 3 dropped (err_unit)
        logic [7:0] opc;
        logic [5:0] vs1;
        logic [5:0] vs2;
        logic [5:0] rd;
        int         exp_cyc;  // required cycle, -1 = any
        int         gap;      // required distance from previous event, 0 = any
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_evt = 0;
    int   n_alu = 0, n_mtx = 0, n_lsu = 0, n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    task automatic expect_ev(input logic [1:0] k, input logic [7:0] opc, input logic [5:0] s1,
                             input logic [5:0] s2, input logic [5:0] d, input int ec, input int gp);
        exp_t e;
        e.kind = k; e.opc = opc; e.vs1 = s1; e.vs2 = s2; e.rd = d; e.exp_cyc = ec; e.gap = gp;
        exp_q.push_back(e);
    endtask

    // Offer one instruction, holding it until accepted; returns the accept edge index.
    task automatic send(input logic [1:0] u, input logic [7:0] opc, input logic [5:0] s1,
                        input logic [5:0] s2, input logic [5:0] d, output int acc);
        int waitc;
        waitc = 0;
        @(negedge clk);
        inst_vld = 1'b1; inst_unit = u; inst_opcode = opc;
        inst_vs1 = s1; inst_vs2 = s2; inst_rd = d;
        while (!inst_rdy && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        if (!inst_rdy) begin
            chk("send_accept_timeout", 0, 1);
            acc = -1;
        end else begin
            acc = cyc + 1;
            @(posedge clk);
            #1;
        end
        inst_vld = 1'b0; inst_unit = 2'd0; inst_opcode = 8'd0;
        inst_vs1 = 6'd0; inst_vs2 = 6'd0; inst_rd = 6'd0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending_events", exp_q.size(), 0);
        repeat (10) @(negedge clk);
    endtask

    // Monitor: compare every presented event with the scoreboard head.
    always @(negedge clk) begin
        int nact;
        logic [1:0] k;
        logic [7:0] g_opc;
        logic [5:0] g_vs1, g_vs2, g_rd;
        exp_t e;
        logic bad;
        nact = int'(valu_op_en) + int'(vmtx_op_en) + int'(vlsu_op_en) + int'(err_unit);
        bad = (!valu_op_en && ((valu_opcode != 8'd0) || (valu_vs1 != 6'd0) || (valu_vs2 != 6'd0) || (valu_rd != 5'd0)))
           || (!vmtx_op_en && ((vmtx_opcode != 8'd0) || (vmtx_vs1 != 6'd0) || (vmtx_vs2 != 6'd0)))
           || (!vlsu_op_en && ((vlsu_opcode != 8'd0) || (vlsu_vs1 != 6'd0) || (vlsu_vs2 != 6'd0) || (vlsu_rd != 6'd0)));
        chk("inactive_fields_zero", int'(bad), 0);
        if (nact > 1) begin
            chk("single_event_per_cycle", nact, 1);
        end else if (nact == 1) begin
            g_opc = 8'd0; g_vs1 = 6'd0; g_vs2 = 6'd0; g_rd = 6'd0;
            if (valu_op_en) begin
                k = 2'd0; n_alu++;
                g_opc = valu_opcode; g_vs1 = valu_vs1; g_vs2 = valu_vs2; g_rd = {1'b0, valu_rd};
            end else if (vmtx_op_en) begin
                k = 2'd1; n_mtx++;
                g_opc = vmtx_opcode; g_vs1 = vmtx_vs1; g_vs2 = vmtx_vs2;
            end else if (vlsu_op_en) begin
                k = 2'd2; n_lsu++;
                g_opc = vlsu_opcode; g_vs1 = vlsu_vs1; g_vs2 = vlsu_vs2; g_rd = vlsu_rd;
            end else begin
                k = 2'd3; n_err++;
            end
            if (exp_q.size() == 0) begin
                chk("unexpected_event_kind", int'(k), -1);
            end else begin
                e = exp_q.pop_front();
                chk("event_kind", int'(k), int'(e.kind));
                if (k == e.kind && k != 2'd3) begin
                    chk("event_opcode", int'(g_opc), int'(e.opc));
                    chk("event_vs1", int'(g_vs1), int'(e.vs1));
                    chk("event_vs2", int'(g_vs2), int'(e.vs2));
                    if (k == 2'd0) chk("event_alu_rd", int'(g_rd), int'(e.rd[4:0]));
                    if (k == 2'd2) chk("event_lsu_rd", int'(g_rd), int'(e.rd));
                end
                if (e.exp_cyc >= 0) chk("event_cycle", cyc, e.exp_cyc);
                if (e.gap > 0) chk("event_gap", cyc - last_evt, e.gap);
            end
            last_evt = cyc;
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int a0, a1, a2, a3, a4, a5, a6;
        int s_alu, s_mtx, s_lsu, s_err;

        // Reset state
        #12;
        chk("reset_fifo_cnt", int'(fifo_cnt), 0);
        chk("reset_inst_rdy", int'(inst_rdy), 0);
        chk("reset_op_en", int'({valu_op_en, vmtx_op_en, vlsu_op_en, err_unit}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_after_reset", int'(inst_rdy), 1);

        // Single ALU op: accepted at edge T, op_en in the cycle after T+1
        send(UNIT_ALU, 8'h11, 6'd3, 6'd4, 6'd9, a0);
        expect_ev(2'd0, 8'h11, 6'd3, 6'd4, 6'd9, a0 + 1, 0);
        drain();

        // Back-to-back MTX ops 8 cycles apart, ALU right behind the second
        send(UNIT_MTX, 8'h21, 6'd1, 6'd2, 6'd0, a0);
        expect_ev(2'd1, 8'h21, 6'd1, 6'd2, 6'd0, a0 + 1, 0);
        send(UNIT_MTX, 8'h22, 6'd5, 6'd6, 6'd0, a1);
        expect_ev(2'd1, 8'h22, 6'd5, 6'd6, 6'd0, -1, 8);
        send(UNIT_ALU, 8'h23, 6'd7, 6'd8, 6'd10, a2);
        expect_ev(2'd0, 8'h23, 6'd7, 6'd8, 6'd10, -1, 1);
        drain();

        // Load rd=5 then ALU reading v5: ALU issues 2 cycles after the load
        send(UNIT_LSU, 8'h31, 6'd1, 6'd2, 6'd5, a0);
        expect_ev(2'd2, 8'h31, 6'd1, 6'd2, 6'd5, a0 + 1, 0);
        send(UNIT_ALU, 8'h32, 6'd6, 6'd5, 6'd7, a1);
        expect_ev(2'd0, 8'h32, 6'd6, 6'd5, 6'd7, -1, 2);
        drain();

        // Fill the queue behind a stalled MTX head
        send(UNIT_MTX, 8'h40, 6'd1, 6'd1, 6'd0, a0);
        expect_ev(2'd1, 8'h40, 6'd1, 6'd1, 6'd0, a0 + 1, 0);
        send(UNIT_MTX, 8'h41, 6'd2, 6'd2, 6'd0, a1);
        expect_ev(2'd1, 8'h41, 6'd2, 6'd2, 6'd0, -1, 8);
        send(UNIT_ALU, 8'h42, 6'd3, 6'd3, 6'd11, a2);
        expect_ev(2'd0, 8'h42, 6'd3, 6'd3, 6'd11, -1, 1);
        send(UNIT_ALU, 8'h43, 6'd4, 6'd4, 6'd12, a3);
        expect_ev(2'd0, 8'h43, 6'd4, 6'd4, 6'd12, -1, 1);
        send(UNIT_ALU, 8'h44, 6'd5, 6'd5, 6'd13, a4);
        expect_ev(2'd0, 8'h44, 6'd5, 6'd5, 6'd13, -1, 1);
        @(negedge clk);
        chk("full_fifo_cnt", int'(fifo_cnt), 4);
        chk("full_inst_rdy", int'(inst_rdy), 0);
        send(UNIT_ALU, 8'h45, 6'd6, 6'd6, 6'd14, a5);
        expect_ev(2'd0, 8'h45, 6'd6, 6'd6, 6'd14, -1, 1);
        chk("held_inst_accept_edge", a5, a0 + 10);
        send(UNIT_ALU, 8'h46, 6'd7, 6'd7, 6'd15, a6);
        expect_ev(2'd0, 8'h46, 6'd7, 6'd7, 6'd15, -1, 1);
        drain();

        // Illegal unit between two ALU ops
        s_alu = n_alu; s_mtx = n_mtx; s_lsu = n_lsu; s_err = n_err;
        send(UNIT_ALU, 8'h51, 6'd1, 6'd2, 6'd3, a0);
        expect_ev(2'd0, 8'h51, 6'd1, 6'd2, 6'd3, a0 + 1, 0);
        send(UNIT_ILL, 8'h52, 6'd4, 6'd5, 6'd6, a1);
        expect_ev(2'd3, 8'h00, 6'd0, 6'd0, 6'd0, -1, 1);
        send(UNIT_ALU, 8'h53, 6'd7, 6'd8, 6'd9, a2);
        expect_ev(2'd0, 8'h53, 6'd7, 6'd8, 6'd9, -1, 1);
        drain();
        chk("illegal_alu_pulses", n_alu - s_alu, 2);
        chk("illegal_err_pulses", n_err - s_err, 1);
        chk("illegal_mtx_lsu_pulses", (n_mtx - s_mtx) + (n_lsu - s_lsu), 0);

        // Flush with 3 queued; MTX counter keeps its schedule
        send(UNIT_MTX, 8'h61, 6'd1, 6'd2, 6'd0, a0);
        expect_ev(2'd1, 8'h61, 6'd1, 6'd2, 6'd0, a0 + 1, 0);
        send(UNIT_MTX, 8'h62, 6'd3, 6'd4, 6'd0, a1);
        send(UNIT_ALU, 8'h63, 6'd5, 6'd6, 6'd7, a2);
        send(UNIT_ALU, 8'h64, 6'd8, 6'd9, 6'd10, a3);
        @(negedge clk);
        chk("pre_flush_fifo_cnt", int'(fifo_cnt), 3);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("post_flush_fifo_cnt", int'(fifo_cnt), 0);
        chk("post_flush_inst_rdy", int'(inst_rdy), 1);
        send(UNIT_MTX, 8'h65, 6'd11, 6'd12, 6'd0, a4);
        expect_ev(2'd1, 8'h65, 6'd11, 6'd12, 6'd0, a0 + 9, 8);
        drain();

        // Reset while the second MTX is stalled
        send(UNIT_MTX, 8'h71, 6'd1, 6'd2, 6'd0, a0);
        expect_ev(2'd1, 8'h71, 6'd1, 6'd2, 6'd0, a0 + 1, 0);
        send(UNIT_MTX, 8'h72, 6'd3, 6'd4, 6'd0, a1);
        send(UNIT_ALU, 8'h73, 6'd5, 6'd6, 6'd7, a2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_fifo_cnt", int'(fifo_cnt), 0);
        chk("midreset_inst_rdy", int'(inst_rdy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midreset_rdy_rise", int'(inst_rdy), 1);
        chk("midreset_cnt_after", int'(fifo_cnt), 0);
        drain();
        send(UNIT_ALU, 8'h74, 6'd2, 6'd3, 6'd4, a3);
        expect_ev(2'd0, 8'h74, 6'd2, 6'd3, 6'd4, a3 + 1, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/toy_vec_dispatch.md
TOY_VEC_DISPATCH -- requirements
Module: toy_vec_dispatch

Interface
REQ-001 The block SHALL take all widths (V_OPC_WIDTH, V_REG_IDX_WIDTH) from toy_vpack.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning instruction queue entries (power of two, >=2).
REQ-003 The block SHALL have parameter MTX_BUSY_CYC, default 8, meaning minimum cycles between consecutive matrix issues (>=1).
REQ-004 The block SHALL have parameter LSU_WB_CYC, default 2, meaning cycles a load destination stays pending after issue (>=1).
REQ-005 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous queue clear.
- inst_vld  in  1  instruction offered.
- inst_rdy  out  1  queue can accept.
- inst_unit  in  2  target unit: 0=ALU, 1=MTX, 2=LSU, 3=illegal.
- inst_opcode  in  V_OPC_WIDTH  opcode.
- inst_vs1, inst_vs2  in  V_REG_IDX_WIDTH  sources.
- inst_rd  in  V_REG_IDX_WIDTH  destination; ALU uses low 5 bits.
- vmtx_op_en, vmtx_opcode, vmtx_vs1, vmtx_vs2  out  1/OPC/IDX/IDX  matrix issue.
- valu_op_en, valu_opcode, valu_vs1, valu_vs2, valu_rd  out  1/OPC/IDX/IDX/5  ALU issue.
- vlsu_op_en, vlsu_opcode, vlsu_vs1, vlsu_vs2, vlsu_rd  out  1/OPC/IDX/IDX/IDX  LSU issue.
- fifo_cnt  out  clog2(FIFO_DEPTH)+1  queue occupancy.
- err_unit  out  1  one-cycle pulse when an illegal instruction is dropped.

Function
REQ-006 The block SHALL accept an instruction on a rising edge where inst_vld=1 and inst_rdy=1, and SHALL drive inst_rdy = (fifo_cnt < FIFO_DEPTH) from registered occupancy only; a same-cycle pop SHALL NOT raise inst_rdy.
REQ-007 The block SHALL evaluate only the queue head and SHALL issue in order; a stalled head SHALL block all younger entries.
REQ-008 The block SHALL issue a head at most one instruction per cycle, popping it on the same edge that registers the issue outputs.
REQ-009 The block SHALL hold the issued unit's op_en high for exactly one cycle after the issue edge, with its fields equal to the instruction's; every op_en SHALL otherwise be 0 and every field SHALL be 0.
REQ-010 Minimum latency SHALL be: accepted at edge T, hazard-free, op_en high in the cycle following edge T+1.
REQ-011 The block SHALL drop a head with inst_unit=3 without issuing it, popping it and pulsing err_unit for one cycle on the same edge; such a drop SHALL NOT wait on hazards.
REQ-012 The block SHALL maintain an MTX busy counter that loads MTX_BUSY_CYC-1 on each MTX issue and decrements to 0 while nonzero; an MTX head SHALL be eligible only when the counter is 0, giving consecutive vmtx_op_en pulses exactly MTX_BUSY_CYC cycles apart when back-to-back.
REQ-013 The block SHALL keep an LSU_WB_CYC-deep delay line of (valid, rd) entries, entered on each LSU issue and each aged out after LSU_WB_CYC cycles.
REQ-014 A head SHALL stall (RAW) while its vs1 or vs2 matches any valid delay-line rd.
REQ-015 An LSU head SHALL also stall (WAW) while its rd matches any valid delay-line rd.
REQ-016 ALU and MTX instructions SHALL NOT enter the delay line.
REQ-017 When flush=1 the block SHALL, at the next edge, empty the queue and suppress any issue, push or err_unit on that edge; the MTX counter and delay line SHALL continue aging unaffected.
REQ-018 Queue pointers SHALL wrap modulo FIFO_DEPTH; fifo_cnt SHALL equal pushes minus pops, and a simultaneous push and pop SHALL leave it unchanged.

Reset
REQ-019 When rst_n=0 the block SHALL immediately, regardless of clk, set the queue empty, fifo_cnt=0, inst_rdy=0, all op_en=0, all fields=0, err_unit=0, the MTX counter=0 and all delay-line entries invalid.
REQ-020 inst_rdy SHALL rise in the first cycle after rst_n deasserts.
REQ-021 A reset mid-stall SHALL discard all queued instructions, none of which SHALL issue afterwards.

Verification
REQ-022 The bench SHALL cover: single ALU op (unit 0, opc 0x11, vs1 3, vs2 4, rd 9) accepted at edge T -> valu_op_en high only in the cycle after T+1 with those fields; all others 0.
REQ-023 The bench SHALL cover: two back-to-back MTX ops, MTX_BUSY_CYC=8 -> vmtx_op_en pulses exactly 8 cycles apart, and a following ALU op waits behind the second.
REQ-024 The bench SHALL cover: LSU load rd=5, then ALU op with vs2=5, LSU_WB_CYC=2 -> ALU issues exactly 2 cycles after the LSU issue, not earlier.
REQ-025 The bench SHALL cover: 6 pushes with FIFO_DEPTH=4 and the head stalled -> inst_rdy=0 once fifo_cnt=4, the 5th instruction is held by the source, and no entry is lost or duplicated.
REQ-026 The bench SHALL cover: illegal unit=3 between two ALU ops -> one err_unit pulse, exactly two valu_op_en pulses, and nothing on MTX or LSU.
REQ-027 The bench SHALL cover: flush with 3 queued, and separately rst_n low mid-stall -> fifo_cnt=0 next cycle, no op_en from the discarded entries, and the MTX counter still expires on schedule after flush.
